systolic_feed_ctrl: RTL and testbench



---
 rtl/systolic_feed_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_feed_ctrl
// Brief    : Operand feeder for an NxN systolic array. It walks k A-columns and
//            k B-rows, skews the lanes, drains the array and pulses done.
//            Optional macro SYSTOLIC_PERF_CNT_EN adds the cyc_cnt busy counter.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_feed_ctrl #(
  parameter int N  = 16,
  parameter int DW = 16,
  parameter int KW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [KW-1:0]   k,
  input  logic            abort,
  output logic [KW-1:0]   a_addr,
  output logic [KW-1:0]   b_addr,
  input  logic [N*DW-1:0] a_rdata,
  input  logic [N*DW-1:0] b_rdata,
  output logic [N*DW-1:0] a_out,
  output logic [N*DW-1:0] b_out,
  output logic            arr_clr,
  output logic            busy,
  output logic            done
`ifdef SYSTOLIC_PERF_CNT_EN
  ,
  output logic [31:0]     cyc_cnt
`endif
);

  localparam int c_dcw = (2*N > 1) ? $clog2(2*N) : 1;
  localparam logic [c_dcw-1:0] c_drain_last = c_dcw'(2*N-1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     r_cnt;
  logic [c_dcw-1:0]  r_dcnt;
  logic              r_feed_d;
  logic [KW-1:0]     w_last_addr;
  logic              w_accept;
  logic [N*DW-1:0]   w_a_in;
  logic [N*DW-1:0]   w_b_in;

  assign w_accept    = (r_state == ST_IDLE) && start && !abort && (k != '0);
  assign w_last_addr = r_k - KW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    arr_clr     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        arr_clr     = 1'b1;
        w_state_nxt = ST_FEED;
      end
      ST_FEED: begin
        if (r_cnt == w_last_addr) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_dcnt == c_drain_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort outranks every other transition, including a start in IDLE.
    if (abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k <= '0;
    end else if (w_accept) begin
      r_k <= k;
    end
  end

  // Address counter returns to 0 on the last FEED cycle, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == ST_FEED) && !abort && (r_cnt != w_last_addr)) begin
      r_cnt <= r_cnt + KW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt <= '0;
    end else if ((r_state == ST_DRAIN) && !abort) begin
      r_dcnt <= r_dcnt + c_dcw'(1);
    end else begin
      r_dcnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_feed_d <= 1'b0;
    end else begin
      r_feed_d <= (r_state == ST_FEED) && !abort;
    end
  end

  assign a_addr = r_cnt;
  assign b_addr = r_cnt;

  // Read data is only meaningful the cycle after a FEED address; zero otherwise.
  assign w_a_in = r_feed_d ? a_rdata : '0;
  assign w_b_in = r_feed_d ? b_rdata : '0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      if (gi == 0) begin : g_direct
        assign a_out[DW-1:0] = w_a_in[DW-1:0];
        assign b_out[DW-1:0] = w_b_in[DW-1:0];
      end else begin : g_skew
        logic [DW-1:0] r_a_pipe [gi];
        logic [DW-1:0] r_b_pipe [gi];

        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            for (int j = 0; j < gi; j++) begin
              r_a_pipe[j] <= '0;
              r_b_pipe[j] <= '0;
            end
          end else if (abort) begin
            for (int j = 0; j < gi; j++) begin
              r_a_pipe[j] <= '0;
              r_b_pipe[j] <= '0;
            end
          end else begin
            r_a_pipe[0] <= w_a_in[gi*DW +: DW];
            r_b_pipe[0] <= w_b_in[gi*DW +: DW];
            for (int j = 1; j < gi; j++) begin
              r_a_pipe[j] <= r_a_pipe[j-1];
              r_b_pipe[j] <= r_b_pipe[j-1];
            end
          end
        end

        assign a_out[gi*DW +: DW] = r_a_pipe[gi-1];
        assign b_out[gi*DW +: DW] = r_b_pipe[gi-1];
      end
    end
  endgenerate

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc_cnt <= '0;
    end else if (busy && (r_cyc_cnt != 32'hFFFF_FFFF)) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_feed_ctrl
// Brief    : Self-checking bench for systolic_feed_ctrl (timeline reference
//            model plus directed latency/boundary checks and random traffic).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_feed_ctrl;
  localparam int N  = 16;
  localparam int DW = 16;
  localparam int KW = 8;
  localparam int TAIL = 2*N + 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [KW-1:0]   k = '0;
  logic [KW-1:0]   a_addr, b_addr;
  logic [N*DW-1:0] a_rdata = '0;
  logic [N*DW-1:0] b_rdata = '0;
  logic [N*DW-1:0] a_out, b_out;
  logic            arr_clr, busy, done;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0]     cyc_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] a_mem [256][N];
  logic [DW-1:0] b_mem [256][N];

  // Reference model: a pass is a timeline indexed by cycles since acceptance.
  bit     m_active = 1'b0;
  int     m_t = 0;
  int     m_k = 0;
  longint m_busy = 0;

  int cyc = 0;
  int done_cnt = 0, busy_cnt = 0, clr_cnt = 0;
  int last_done_cyc = -1, last_clr_cyc = -1;
  int first_nz0 = -1, first_nz15 = -1;
  logic [DW-1:0] first_val15 = '0;
  logic [KW-1:0] addr_qa = '0, addr_qb = '0;

  systolic_feed_ctrl #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .k       (k),
    .abort   (abort),
    .a_addr  (a_addr),
    .b_addr  (b_addr),
    .a_rdata (a_rdata),
    .b_rdata (b_rdata),
    .a_out   (a_out),
    .b_out   (b_out),
    .arr_clr (arr_clr),
    .busy    (busy),
    .done    (done)
`ifdef SYSTOLIC_PERF_CNT_EN
    ,
    .cyc_cnt (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_t      = 0;
      m_k      = 0;
      m_busy   = 0;
    end else begin
      if (m_active) m_busy++;
      if (m_active) begin
        if (abort || (m_t == m_k + TAIL)) m_active = 1'b0;
        else m_t++;
      end else if (start && !abort && (k != '0)) begin
        m_active = 1'b1;
        m_t      = 1;
        m_k      = int'(k);
      end
    end
  end

  function automatic logic [N*DW-1:0] exp_lanes(input bit use_b);
    logic [N*DW-1:0] v;
    int j;
    v = '0;
    for (int i = 0; i < N; i++) begin
      j = m_t - 3 - i;
      if (m_active && (j >= 0) && (j < m_k))
        v[i*DW +: DW] = use_b ? b_mem[j][i] : a_mem[j][i];
    end
    return v;
  endfunction

  function automatic logic [KW-1:0] exp_addr();
    if (m_active && (m_t >= 2) && (m_t <= m_k + 1)) return KW'(m_t - 2);
    return '0;
  endfunction

  task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      chk("busy",    busy,    m_active);
      chk("done",    done,    m_active && (m_t == m_k + TAIL));
      chk("arr_clr", arr_clr, m_active && (m_t == 1));
      chk("a_addr",  a_addr,  exp_addr());
      chk("b_addr",  b_addr,  exp_addr());
      chk("a_out",   a_out,   exp_lanes(1'b0));
      chk("b_out",   b_out,   exp_lanes(1'b1));
`ifdef SYSTOLIC_PERF_CNT_EN
      chk("cyc_cnt", cyc_cnt, m_busy[31:0]);
`endif
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (arr_clr) begin clr_cnt++; last_clr_cyc = cyc; end
      if ((first_nz0 < 0) && (a_out[DW-1:0] != '0)) first_nz0 = cyc;
      if ((first_nz15 < 0) && (a_out[15*DW +: DW] != '0)) begin
        first_nz15  = cyc;
        first_val15 = a_out[15*DW +: DW];
      end
      addr_qa = a_addr;
      addr_qb = b_addr;
    end
  end

  // Operand buffers: one-cycle read latency from the address seen last cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        a_rdata[i*DW +: DW] = a_mem[addr_qa][i];
        b_rdata[i*DW +: DW] = b_mem[addr_qb][i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input int kv);
    start = 1'b1;
    k     = KW'(kv);
    tick();
    start = 1'b0;
  endtask

  int s, d0, b0, c0;

  initial begin
    for (int j = 0; j < 256; j++)
      for (int i = 0; i < N; i++) begin
        a_mem[j][i] = DW'(16'h0100 + i);
        b_mem[j][i] = DW'(16'h0200 + i);
      end

    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy",  busy,    1'b0);
    chk("reset_done",  done,    1'b0);
    chk("reset_clr",   arr_clr, 1'b0);
    chk("reset_addr",  a_addr,  '0);
    chk("reset_a_out", a_out,   '0);
    chk("reset_b_out", b_out,   '0);
    rst = 1'b1;
    tick();

    // k=4 pass with lane-indexed operands
    s = cyc; d0 = done_cnt; b0 = busy_cnt; c0 = clr_cnt;
    do_start(4);
    idle_cycles(45);
    chk_int("k4_latency",  last_done_cyc - s, 38);
    chk_int("k4_busy_len", busy_cnt - b0, 38);
    chk_int("k4_clr_len",  clr_cnt - c0, 1);
    chk_int("k4_done_cnt", done_cnt - d0, 1);
    chk_int("lane0_first",  first_nz0 - last_clr_cyc, 2);
    chk_int("lane15_first", first_nz15 - (last_clr_cyc + 1), 16);
    chk_int("lane15_val",   first_val15, 16'h010F);

    s = cyc;
    do_start(4);
    idle_cycles(40);
    chk_int("k4b_latency", last_done_cyc - s, 38);
`ifdef SYSTOLIC_PERF_CNT_EN
    chk_int("perf_two_passes", cyc_cnt, 76);
`endif

    for (int j = 0; j < 256; j++)
      for (int i = 0; i < N; i++) begin
        a_mem[j][i] = DW'($urandom);
        b_mem[j][i] = DW'($urandom);
      end

    // k=0 is ignored, then k=1 runs
    d0 = done_cnt; b0 = busy_cnt; c0 = clr_cnt;
    do_start(0);
    idle_cycles(5);
    chk_int("k0_busy", busy_cnt - b0, 0);
    chk_int("k0_clr",  clr_cnt - c0, 0);
    chk_int("k0_done", done_cnt - d0, 0);
    s = cyc;
    do_start(1);
    idle_cycles(40);
    chk_int("k1_latency", last_done_cyc - s, 35);

    // abort in the 5th FEED cycle of a k=8 pass
    s = cyc; d0 = done_cnt;
    do_start(8);
    idle_cycles(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy",  busy,  1'b0);
    chk("abort_a_out", a_out, '0);
    chk("abort_b_out", b_out, '0);
    idle_cycles(50);
    chk_int("abort_no_done", done_cnt - d0, 0);
    s = cyc;
    do_start(2);
    idle_cycles(40);
    chk_int("k2_latency", last_done_cyc - s, 36);

    // reset pulse during DRAIN
    d0 = done_cnt;
    do_start(3);
    idle_cycles(10);
    rst = 1'b0;
    #1;
    chk("rst_busy",  busy,    1'b0);
    chk("rst_done",  done,    1'b0);
    chk("rst_clr",   arr_clr, 1'b0);
    chk("rst_addr",  a_addr,  '0);
    chk("rst_a_out", a_out,   '0);
    chk("rst_b_out", b_out,   '0);
    tick();
    rst = 1'b1;
    idle_cycles(40);
    chk_int("rst_no_done", done_cnt - d0, 0);

    // start while busy is ignored
    s = cyc; d0 = done_cnt;
    do_start(3);
    idle_cycles(5);
    start = 1'b1; k = 8'd9;
    tick();
    start = 1'b0;
    idle_cycles(45);
    chk_int("busy_start_done_cnt", done_cnt - d0, 1);
    chk_int("k3_latency", last_done_cyc - s, 37);

    // random traffic, including k changes mid-pass and rare aborts
    repeat (1500) begin
      start = ($urandom_range(0, 99) < 10);
      abort = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) k = '0;
      else if ($urandom_range(0, 49) == 0) k = KW'($urandom_range(200, 255));
      else k = KW'($urandom_range(1, 12));
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    idle_cycles(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
